// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, ALU and mul/div
// operation codes, forwarding selects and the mul/div engine state type.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} mdState_e;

    function automatic logic isMdStart(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Select 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [DATA_W-1:0] fwdMux(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] regVal,
                                                 input logic [DATA_W-1:0] wbVal,
                                                 input logic [DATA_W-1:0] memVal);
        case (sel)
            FWD_WB:  return wbVal;
            FWD_MEM: return memVal;
            default: return regVal;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide engine holding HI/LO: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, signs fixed at the end.
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_CYCLES - 1);

    mdState_e          state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       acc_q;
    logic [63:0]       acc_d;
    logic [31:0]       opnd_q;
    logic [31:0]       dividend_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              isDiv_q;
    logic              negRes_q;
    logic              negRem_q;
    logic              divZero_q;

    logic              signedOp;
    logic              aNeg;
    logic              bNeg;
    logic [31:0]       absA;
    logic [31:0]       absB;
    logic [32:0]       mulSum;
    logic [32:0]       divShift;
    logic [31:0]       divDiff;
    logic              divGeq;
    logic [63:0]       prodFix;
    logic [31:0]       quotFix;
    logic [31:0]       remFix;

    always_comb begin
        signedOp = (op_i == MD_MULT) || (op_i == MD_DIV);
        aNeg     = signedOp && a_i[31];
        bNeg     = signedOp && b_i[31];
        absA     = aNeg ? -a_i : a_i;
        absB     = bNeg ? -b_i : b_i;
    end

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        divShift = {acc_q[63:32], acc_q[31]};
        divGeq   = divShift >= {1'b0, opnd_q};
        divDiff  = divShift[31:0] - opnd_q;
        if (isDiv_q) begin
            acc_d = {(divGeq ? divDiff : divShift[31:0]), acc_q[30:0], divGeq};
        end else begin
            acc_d = {mulSum, acc_q[31:1]};
        end
        prodFix = negRes_q ? -acc_d : acc_d;
        quotFix = negRes_q ? -acc_d[31:0] : acc_d[31:0];
        remFix  = negRem_q ? -acc_d[63:32] : acc_d[63:32];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            isDiv_q    <= 1'b0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q    <= MD_BUSY;
                        cnt_q      <= '0;
                        isDiv_q    <= (op_i == MD_DIV) || (op_i == MD_DIVU);
                        negRes_q   <= aNeg ^ bNeg;
                        negRem_q   <= aNeg;
                        divZero_q  <= (b_i == '0);
                        dividend_q <= a_i;
                        if ((op_i == MD_DIV) || (op_i == MD_DIVU)) begin
                            acc_q  <= {32'd0, absA};
                            opnd_q <= absB;
                        end else begin
                            acc_q  <= {32'd0, absB};
                            opnd_q <= absA;
                        end
                    end
                end
                MD_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= MD_IDLE;
                        if (!isDiv_q) begin
                            {hi_q, lo_q} <= prodFix;
                        end else if (divZero_q) begin
                            hi_q <= dividend_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= remFix;
                            lo_q <= quotFix;
                        end
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO reads, mul/div stall request
// and the EX/MEM pipeline register.
module ex_stage
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwritee,
    input  logic              memtorege,
    input  logic              memwritee,
    input  logic              alusrce,
    input  logic              regdste,
    input  logic [2:0]        alucontrole,
    input  logic [2:0]        mdope,
    input  logic [DATA_W-1:0] rd1e,
    input  logic [DATA_W-1:0] rd2e,
    input  logic [DATA_W-1:0] signimme,
    input  logic [4:0]        rte,
    input  logic [4:0]        rde,
    input  logic [1:0]        forwardae,
    input  logic [1:0]        forwardbe,
    input  logic [DATA_W-1:0] resultw,
    output logic              regwritem,
    output logic              memtoregm,
    output logic              memwritem,
    output logic [DATA_W-1:0] aluoutm,
    output logic [DATA_W-1:0] writedatam,
    output logic [4:0]        writeregm,
    output logic              mdstalle
);

    logic [DATA_W-1:0] srcae;
    logic [DATA_W-1:0] srcbe;
    logic [DATA_W-1:0] writedatae;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] aluoute;
    logic [DATA_W-1:0] hiVal;
    logic [DATA_W-1:0] loVal;
    logic [4:0]        writerege;
    logic              mdBusy;
    logic              mdStart;

    logic              regwritem_q;
    logic              memtoregm_q;
    logic              memwritem_q;
    logic [DATA_W-1:0] aluoutm_q;
    logic [DATA_W-1:0] writedatam_q;
    logic [4:0]        writeregm_q;

    always_comb begin
        srcae      = fwdMux(forwardae, rd1e, resultw, aluoutm_q);
        writedatae = fwdMux(forwardbe, rd2e, resultw, aluoutm_q);
        srcbe      = alusrce ? signimme : writedatae;
        writerege  = regdste ? rde : rte;
    end

    always_comb begin
        case (alucontrole)
            ALU_ADD: aluResult = srcae + srcbe;
            ALU_SUB: aluResult = srcae - srcbe;
            ALU_AND: aluResult = srcae & srcbe;
            ALU_OR:  aluResult = srcae | srcbe;
            ALU_SLT: aluResult = {31'd0, $signed(srcae) < $signed(srcbe)};
            default: aluResult = '0;
        endcase
        case (mdope)
            MD_MFHI: aluoute = hiVal;
            MD_MFLO: aluoute = loVal;
            default: aluoute = aluResult;
        endcase
    end

    // Any mul/div-class op arriving while the engine is busy must wait; plain ALU ops never do.
    assign mdstalle = mdBusy && (mdope != MD_NONE);
    assign mdStart  = !mdBusy && isMdStart(mdope);

    ex_muldiv #(
        .MD_CYCLES(MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start_i(mdStart),
        .op_i   (mdope),
        .a_i    (srcae),
        .b_i    (srcbe),
        .busy_o (mdBusy),
        .hi_o   (hiVal),
        .lo_o   (loVal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset || mdstalle) begin
            regwritem_q  <= 1'b0;
            memtoregm_q  <= 1'b0;
            memwritem_q  <= 1'b0;
            aluoutm_q    <= '0;
            writedatam_q <= '0;
            writeregm_q  <= '0;
        end else begin
            regwritem_q  <= regwritee;
            memtoregm_q  <= memtorege;
            memwritem_q  <= memwritee;
            aluoutm_q    <= aluoute;
            writedatam_q <= writedatae;
            writeregm_q  <= writerege;
        end
    end

    assign regwritem  = regwritem_q;
    assign memtoregm  = memtoregm_q;
    assign memwritem  = memwritem_q;
    assign aluoutm    = aluoutm_q;
    assign writedatam = writedatam_q;
    assign writeregm  = writeregm_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver predicts each EX/MEM result from a
// behavioural model and queues it; a monitor compares after every clock edge.
module tb_ex_stage;
    import mips_pkg::*;

    typedef struct {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  aluctl;
        logic [2:0]  mdop;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] resw;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } instr_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [4:0]  writereg;
    } mOut_t;

    logic        clk;
    logic        reset;
    logic        regwritee, memtorege, memwritee, alusrce, regdste;
    logic [2:0]  alucontrole, mdope;
    logic [31:0] rd1e, rd2e, signimme, resultw;
    logic [4:0]  rte, rde;
    logic [1:0]  forwardae, forwardbe;
    logic        regwritem, memtoregm, memwritem, mdstalle;
    logic [31:0] aluoutm, writedatam;
    logic [4:0]  writeregm;

    int checks = 0;
    int failures = 0;
    mOut_t sbQ[$];

    logic [31:0] mHi, mLo, pendHi, pendLo, mLastAlu;
    int          mdRemain;

    ex_stage #(.MD_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
        .alusrce(alusrce), .regdste(regdste),
        .alucontrole(alucontrole), .mdope(mdope),
        .rd1e(rd1e), .rd2e(rd2e), .signimme(signimme),
        .rte(rte), .rde(rde),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .resultw(resultw),
        .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem),
        .aluoutm(aluoutm), .writedatam(writedatam), .writeregm(writeregm),
        .mdstalle(mdstalle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pickSel(input logic [1:0] s, input logic [31:0] r,
                                            input logic [31:0] w, input logic [31:0] m);
        if (s == 2'b01) return w;
        if (s == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] aluRef(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (ctl)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Mul/div results straight from integer arithmetic, including the architected corner cases.
    task automatic mdRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b001: begin
                sp = longint'(sa) * longint'(sb);
                {pendHi, pendLo} = sp;
            end
            3'b010: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                {pendHi, pendLo} = up;
            end
            3'b011: begin
                if (b == 0) begin pendLo = 32'hFFFFFFFF; pendHi = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin pendLo = 32'h80000000; pendHi = 0; end
                else begin pendLo = sa / sb; pendHi = sa % sb; end
            end
            default: begin
                if (b == 0) begin pendLo = 32'hFFFFFFFF; pendHi = a; end
                else begin pendLo = a / b; pendHi = a % b; end
            end
        endcase
    endtask

    task automatic modelStep(input instr_t in, output mOut_t exp, output logic stall);
        logic [31:0] srcA, wd, srcB, res;
        srcA  = pickSel(in.fa, in.rd1, in.resw, mLastAlu);
        wd    = pickSel(in.fb, in.rd2, in.resw, mLastAlu);
        srcB  = in.alusrc ? in.imm : wd;
        stall = (mdRemain > 0) && (in.mdop != 3'b000);
        if (stall) begin
            exp = '0;
        end else begin
            if (in.mdop == 3'b101)      res = mHi;
            else if (in.mdop == 3'b110) res = mLo;
            else                        res = aluRef(in.aluctl, srcA, srcB);
            exp = '{in.regwrite, in.memtoreg, in.memwrite, res, wd, in.regdst ? in.rd : in.rt};
        end
        if (mdRemain > 0) begin
            mdRemain--;
            if (mdRemain == 0) begin mHi = pendHi; mLo = pendLo; end
        end else if (in.mdop >= 3'b001 && in.mdop <= 3'b100) begin
            mdRef(in.mdop, srcA, srcB);
            mdRemain = 32;
        end
        mLastAlu = exp.aluout;
    endtask

    task automatic modelReset();
        mHi = 0; mLo = 0; pendHi = 0; pendLo = 0; mLastAlu = 0; mdRemain = 0;
    endtask

    task automatic drive(input instr_t in);
        regwritee = in.regwrite; memtorege = in.memtoreg; memwritee = in.memwrite;
        alusrce = in.alusrc; regdste = in.regdst; alucontrole = in.aluctl; mdope = in.mdop;
        rd1e = in.rd1; rd2e = in.rd2; signimme = in.imm; resultw = in.resw;
        rte = in.rt; rde = in.rd; forwardae = in.fa; forwardbe = in.fb;
    endtask

    function automatic instr_t mkInstr(input logic [2:0] ctl, input logic [2:0] md,
                                       input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i.regwrite = 1'b1; i.memtoreg = 1'b0; i.memwrite = 1'b0;
        i.alusrc = 1'b0; i.regdst = 1'b1; i.aluctl = ctl; i.mdop = md;
        i.rd1 = a; i.rd2 = b; i.imm = $urandom; i.resw = $urandom;
        i.rt = 5'($urandom); i.rd = 5'($urandom); i.fa = 2'b00; i.fb = 2'b00;
        return i;
    endfunction

    function automatic logic [31:0] pickVal();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
        return $urandom;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        int r;
        i = mkInstr(3'($urandom), 3'b000, pickVal(), pickVal());
        i.regwrite = 1'($urandom); i.memtoreg = 1'($urandom); i.memwrite = 1'($urandom);
        i.alusrc = 1'($urandom); i.regdst = 1'($urandom);
        i.imm = pickVal(); i.fa = 2'($urandom); i.fb = 2'($urandom);
        r = $urandom_range(0, 9);
        if (r == 6)      i.mdop = 3'($urandom_range(1, 4));
        else if (r >= 7) i.mdop = 3'($urandom_range(5, 6));
        return i;
    endfunction

    // Issue one E-stage instruction, holding it in place while the stage requests a stall.
    task automatic applyStimulus(input instr_t in);
        mOut_t exp;
        logic  stall;
        int    guard;
        guard = 0;
        do begin
            drive(in);
            modelStep(in, exp, stall);
            #1;
            checkOutput("mdstalle", {71'd0, mdstalle}, {71'd0, stall});
            sbQ.push_back(exp);
            @(posedge clk);
            #2;
            guard++;
        end while (stall && guard < 40);
        if (stall) begin
            checks++;
            failures++;
            $display("[TB] FAIL stall_bound actual=%0d cycles required<40", guard);
        end
    endtask

    initial begin : monitor
        mOut_t exp, act;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                act = {regwritem, memtoregm, memwritem, aluoutm, writedatam, writeregm};
                checkOutput("exmem", act, exp);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        instr_t i;
        modelReset();
        reset = 1'b1;
        drive(mkInstr(ALU_ADD, MD_MFHI, 32'd1, 32'd2));
        #3;
        checkOutput("reset_m", {regwritem, memtoregm, memwritem, aluoutm, writedatam, writeregm}, 72'd0);
        checkOutput("reset_stall", {71'd0, mdstalle}, 72'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        applyStimulus(mkInstr(ALU_ADD, MD_NONE, 32'd60, 32'd40));
        i = mkInstr(ALU_ADD, MD_NONE, 32'd5, 32'd7);
        i.fa = 2'b10;
        applyStimulus(i);
        applyStimulus(mkInstr(ALU_SLT, MD_NONE, 32'hFFFFFFFF, 32'd1));
        applyStimulus(mkInstr(ALU_SUB, MD_NONE, 32'd0, 32'd1));

        applyStimulus(mkInstr(ALU_ADD, MD_MULT, 32'hFFFFFFFF, 32'd2));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MULTU, 32'hFFFFFFFF, 32'd2));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));

        applyStimulus(mkInstr(ALU_ADD, MD_DIV, 32'hFFFFFFF9, 32'd2));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_DIVU, 32'd7, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_DIV, 32'h80000000, 32'hFFFFFFFF));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));

        applyStimulus(mkInstr(ALU_ADD, MD_MULT, 32'd12345, 32'hFFFFFF00));
        applyStimulus(mkInstr(ALU_ADD, MD_NONE, 32'd3, 32'd4));
        i = mkInstr(ALU_ADD, MD_NONE, 32'd1000, 32'hCAFEF00D);
        i.regwrite = 1'b0; i.memwrite = 1'b1; i.alusrc = 1'b1; i.imm = 32'd8; i.fb = 2'b01;
        applyStimulus(i);
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));

        applyStimulus(mkInstr(ALU_ADD, MD_MULT, 32'd7, 32'd9));
        applyStimulus(mkInstr(ALU_ADD, MD_MULT, 32'hFFFFFFFD, 32'd11));
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));

        applyStimulus(mkInstr(ALU_ADD, MD_MULT, 32'h12345678, 32'h9ABCDEF0));
        for (int k = 0; k < 9; k++) applyStimulus(mkInstr(ALU_OR, MD_NONE, 32'($urandom), 32'($urandom)));
        reset = 1'b1;
        sbQ.delete();
        modelReset();
        drive(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        #1;
        checkOutput("midreset_m", {regwritem, memtoregm, memwritem, aluoutm, writedatam, writeregm}, 72'd0);
        checkOutput("midreset_stall", {71'd0, mdstalle}, 72'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));

        for (int k = 0; k < 250; k++) applyStimulus(randInstr());
        for (int k = 0; k < 35; k++) applyStimulus(randInstr());
        applyStimulus(mkInstr(ALU_ADD, MD_MFHI, 32'd0, 32'd0));
        applyStimulus(mkInstr(ALU_ADD, MD_MFLO, 32'd0, 32'd0));

        repeat (2) @(posedge clk);
        #2;
        checkOutput("sb_drain", 72'(sbQ.size()), 72'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
